mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Two-requester arbiter that shares the single 8-bit main-memory interface between two cache controllers, e.g. I-side and D-side.
- Accepts one read or write per grant, drives the memory strobes until the memory signals ready, and returns read data with a one-cycle acknowledge.
- Round-robin fairness between requesters; a timeout prevents a hung memory from locking the bus.
- Sits between the cache controllers' memory-side ports and the main memory model.

Parameters:
- TIMEOUT, 15, max cycles the strobe is held waiting for mem_ready before aborting with error; 0 disables the timeout.
- CNT_W, 4, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- req0 / req1  input  1  request from requester 0 / 1; held until its ack
- we0 / we1  input  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  input  8  access address; stable while req high
- wdata0 / wdata1  input  8  write data; stable while req high
- rdata0 / rdata1  output  8  read data returned to requester 0 / 1
- ack0 / ack1  output  1  one-cycle completion pulse
- err0 / err1  output  1  qualifies ack: access timed out
- mem_read_en  output  1  memory read strobe
- mem_write_en  output  1  memory write strobe
- mem_address  output  8  memory address
- mem_write_data  output  8  memory write data
- mem_read_data  input  8  memory read data, valid when mem_ready is high
- mem_ready  input  1  memory completion, sampled while a strobe is high
- busy  output  1  high whenever state is not IDLE
- owner  output  1  index of the current or last granted requester

Behaviour:
- All outputs are registered. Reset values: every output is 0, the priority pointer prio is 0, and state is IDLE.
- FSM states are IDLE, ACCESS and RESP.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, that requester wins.
  - If both are high, requester prio wins.
  - On a win: latch owner, we, addr and wdata; drive mem_address and mem_write_data; set mem_read_en = ~we or mem_write_en = we; go to ACCESS.
- ACCESS:
  - Strobes, address and data are held constant.
  - Timeout counter increments each cycle mem_ready is low.
  - If mem_ready is high: drop both strobes. For a read, rdata[owner] <= mem_read_data. Go to RESP with err flag 0.
  - Else, if TIMEOUT != 0 and the counter equals TIMEOUT-1 (the strobe has been high for TIMEOUT cycles): drop strobes, set rdata[owner] <= 0 for a read, go to RESP with err flag 1.
- RESP:
  - ack[owner] = 1 and err[owner] = err flag for exactly this one cycle.
  - prio <= ~owner.
  - Counter cleared; go to IDLE.
- Latency: req seen high in cycle n gives a strobe in n+1. With mem_ready high in n+1, ack is in n+2 and the next arbitration happens in n+3. Each extra wait cycle adds 1.
- Throughput: at most one access per 3 cycles; no overlap or pipelining.
- Requesters may drop req on the cycle after ack. A req still high in IDLE is treated as a new request.
- rdata for a port changes only on that port's read completion; writes leave it unchanged.
- Requests from the non-owner are ignored outside IDLE; the non-owner's ack and err stay 0.
- A req dropped before ack is a protocol violation; the access still completes and is acked.
- mem_ready outside ACCESS is ignored.
- Reset mid-operation: strobes and ack drop on the next cycle, no ack is issued for the aborted access, and prio returns to 0.
- busy is high in ACCESS and RESP.

Test Plan:
- Single read from port 0: req0=1, we0=0, addr0=0x3C; memory returns 0xA5 with mem_ready high in the first strobe cycle. Require mem_read_en high for 1 cycle with mem_address=0x3C, then ack0 high in the next cycle, rdata0=0xA5, err0=0.
- Write from port 1 with 3 wait states: we1=1, addr1=0x81, wdata1=0x5A. Require mem_write_en and mem_write_data=0x5A held for 4 cycles, then a single ack1 pulse; rdata1 unchanged.
- Contention after reset: req0 and req1 both held high. Require port 0 served first, then port 1, then port 0, alternating; no port acked twice in a row while the other is waiting.
- Timeout with TIMEOUT=15: mem_ready held low. Require the strobe high for exactly 15 cycles, then ack0 with err0=1 and rdata0=0x00, then a return to IDLE with busy=0.
- Reset mid-ACCESS: assert reset on the 2nd wait cycle. Require strobes 0 on the next cycle, no ack0, prio=0; a subsequent clean read completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester-side and memory-side bundle for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if;
    logic       req0;
    logic       req1;
    logic       we0;
    logic       we1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       ack0;
    logic       ack1;
    logic       err0;
    logic       err1;
    logic       mem_read_en;
    logic       mem_write_en;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic [7:0] mem_read_data;
    logic       mem_ready;
    logic       busy;
    logic       owner;

    // The arbiter itself: serves the requesters, drives the memory strobes.
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  mem_read_data, mem_ready,
        output rdata0, rdata1, ack0, ack1, err0, err1,
        output mem_read_en, mem_write_en, mem_address, mem_write_data,
        output busy, owner
    );

    // Requesters plus memory model, as seen from outside the arbiter.
    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output mem_read_data, mem_ready,
        input  rdata0, rdata1, ack0, ack1, err0, err1,
        input  mem_read_en, mem_write_en, mem_address, mem_write_data,
        input  busy, owner
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin two-port arbiter onto one 8-bit memory, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t           r_state;
    logic             r_prio;
    logic             r_owner;
    logic             r_we;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_rdata0;
    logic [7:0]       r_rdata1;
    logic             r_ack0;
    logic             r_ack1;
    logic             r_err0;
    logic             r_err1;
    logic             r_mem_read_en;
    logic             r_mem_write_en;
    logic [7:0]       r_mem_address;
    logic [7:0]       r_mem_write_data;
    logic             r_busy;

    logic             w_pick;
    logic             w_we;
    logic [7:0]       w_addr;
    logic [7:0]       w_wdata;

    // With both requesting, the pointer decides; otherwise the lone requester wins.
    assign w_pick  = (bus.req0 && bus.req1) ? r_prio : bus.req1;
    assign w_we    = w_pick ? bus.we1    : bus.we0;
    assign w_addr  = w_pick ? bus.addr1  : bus.addr0;
    assign w_wdata = w_pick ? bus.wdata1 : bus.wdata0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_prio           <= 1'b0;
            r_owner          <= 1'b0;
            r_we             <= 1'b0;
            r_cnt            <= '0;
            r_rdata0         <= 8'h00;
            r_rdata1         <= 8'h00;
            r_ack0           <= 1'b0;
            r_ack1           <= 1'b0;
            r_err0           <= 1'b0;
            r_err1           <= 1'b0;
            r_mem_read_en    <= 1'b0;
            r_mem_write_en   <= 1'b0;
            r_mem_address    <= 8'h00;
            r_mem_write_data <= 8'h00;
            r_busy           <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_owner          <= w_pick;
                        r_we             <= w_we;
                        r_mem_address    <= w_addr;
                        r_mem_write_data <= w_wdata;
                        r_mem_read_en    <= ~w_we;
                        r_mem_write_en   <= w_we;
                        r_cnt            <= '0;
                        r_busy           <= 1'b1;
                        r_state          <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (bus.mem_ready) begin
                        r_mem_read_en  <= 1'b0;
                        r_mem_write_en <= 1'b0;
                        if (!r_we) begin
                            if (r_owner) r_rdata1 <= bus.mem_read_data;
                            else         r_rdata0 <= bus.mem_read_data;
                        end
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // Strobe has now been high for TIMEOUT cycles: abort.
                        if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
                            r_mem_read_en  <= 1'b0;
                            r_mem_write_en <= 1'b0;
                            if (!r_we) begin
                                if (r_owner) r_rdata1 <= 8'h00;
                                else         r_rdata0 <= 8'h00;
                            end
                            r_ack0  <= ~r_owner;
                            r_ack1  <= r_owner;
                            r_err0  <= ~r_owner;
                            r_err1  <= r_owner;
                            r_state <= S_RESP;
                        end
                    end
                end

                S_RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_err0  <= 1'b0;
                    r_err1  <= 1'b0;
                    r_prio  <= ~r_owner;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.rdata0         = r_rdata0;
    assign bus.rdata1         = r_rdata1;
    assign bus.ack0           = r_ack0;
    assign bus.ack1           = r_ack1;
    assign bus.err0           = r_err0;
    assign bus.err1           = r_err1;
    assign bus.mem_read_en    = r_mem_read_en;
    assign bus.mem_write_en   = r_mem_write_en;
    assign bus.mem_address    = r_mem_address;
    assign bus.mem_write_data = r_mem_write_data;
    assign bus.busy           = r_busy;
    assign bus.owner          = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   strobe_cycles;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .TIMEOUT (15),
        .CNT_W   (4)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk                = 1'b0;
        reset              = 1'b1;
        n_checks           = 0;
        n_errors           = 0;
        bus.req0           = 1'b0;
        bus.req1           = 1'b0;
        bus.we0            = 1'b0;
        bus.we1            = 1'b0;
        bus.addr0          = 8'h00;
        bus.addr1          = 8'h00;
        bus.wdata0         = 8'h00;
        bus.wdata1         = 8'h00;
        bus.mem_read_data  = 8'h00;
        bus.mem_ready      = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_rd_en",  bus.mem_read_en,  0);
        check("rst_wr_en",  bus.mem_write_en, 0);
        check("rst_addr",   bus.mem_address,  0);
        check("rst_wdata",  bus.mem_write_data, 0);
        check("rst_ack",    {bus.ack0, bus.ack1, bus.err0, bus.err1}, 0);
        check("rst_rdata",  {bus.rdata0, bus.rdata1}, 0);
        check("rst_busy",   bus.busy,  0);
        check("rst_owner",  bus.owner, 0);
        reset = 1'b0;
        tick();

        // Single read from port 0, memory ready in the first strobe cycle
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h3C;
        bus.mem_read_data = 8'hA5; bus.mem_ready = 1'b1;
        tick();
        check("rd0_strobe", bus.mem_read_en,  1);
        check("rd0_wr_en",  bus.mem_write_en, 0);
        check("rd0_addr",   bus.mem_address,  8'h3C);
        check("rd0_busy",   bus.busy, 1);
        check("rd0_noack",  bus.ack0, 0);
        tick();
        check("rd0_drop",   bus.mem_read_en, 0);
        check("rd0_ack",    bus.ack0, 1);
        check("rd0_err",    bus.err0, 0);
        check("rd0_ack1",   bus.ack1, 0);
        check("rd0_rdata",  bus.rdata0, 8'hA5);
        bus.req0 = 1'b0;
        tick();
        check("rd0_ackend", bus.ack0, 0);
        check("rd0_idle",   bus.busy, 0);

        // Write from port 1 with three wait states
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 8'h81; bus.wdata1 = 8'h5A;
        bus.mem_ready = 1'b0; bus.mem_read_data = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) bus.mem_ready = 1'b1;
            check("wr1_strobe", bus.mem_write_en, 1);
            check("wr1_data",   bus.mem_write_data, 8'h5A);
            check("wr1_addr",   bus.mem_address, 8'h81);
            check("wr1_owner",  bus.owner, 1);
            check("wr1_noack",  bus.ack1, 0);
        end
        tick();
        check("wr1_drop",   bus.mem_write_en, 0);
        check("wr1_ack",    bus.ack1, 1);
        check("wr1_err",    bus.err1, 0);
        check("wr1_ack0",   bus.ack0, 0);
        check("wr1_rdata",  bus.rdata1, 8'h00);
        bus.req1 = 1'b0;
        tick();
        check("wr1_ackend", bus.ack1, 0);

        // Contention after reset: both held, must alternate 0,1,0,1
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_read_data = 8'h40 + 8'(i);
            tick();
            check("rr_owner", bus.owner, i % 2);
            check("rr_addr",  bus.mem_address, (i % 2 == 0) ? 8'h10 : 8'h20);
            check("rr_strobe", bus.mem_read_en, 1);
            tick();
            check("rr_ack0",  bus.ack0, (i % 2 == 0) ? 1 : 0);
            check("rr_ack1",  bus.ack1, (i % 2 == 1) ? 1 : 0);
            check("rr_rdata", (i % 2 == 0) ? bus.rdata0 : bus.rdata1, 8'h40 + i);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            tick();
            check("rr_idle", bus.busy, 0);
        end

        // Timeout: memory never ready, strobe must last exactly 15 cycles
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h55;
        bus.mem_ready = 1'b0;
        tick();
        strobe_cycles = 0;
        while (bus.mem_read_en && strobe_cycles < 40) begin
            strobe_cycles++;
            tick();
        end
        check("to_cycles", strobe_cycles, 15);
        check("to_ack",    bus.ack0, 1);
        check("to_err",    bus.err0, 1);
        check("to_rdata",  bus.rdata0, 8'h00);
        check("to_ack1",   {bus.ack1, bus.err1}, 0);
        bus.req0 = 1'b0;
        tick();
        check("to_idle",   bus.busy, 0);
        check("to_errend", bus.err0, 0);

        // Reset during the second wait cycle, then a clean read (prio back to 0)
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h66;
        tick();
        check("mr_strobe", bus.mem_read_en, 1);
        tick();
        reset = 1'b1;
        tick();
        check("mr_drop",   bus.mem_read_en, 0);
        check("mr_noack",  bus.ack0, 0);
        check("mr_busy",   bus.busy, 0);
        reset = 1'b0;
        bus.req0 = 1'b1; bus.addr0 = 8'h77;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h99;
        bus.mem_ready = 1'b1; bus.mem_read_data = 8'hC3;
        tick();
        check("mr_owner",  bus.owner, 0);
        check("mr_addr",   bus.mem_address, 8'h77);
        tick();
        check("mr_ack",    bus.ack0, 1);
        check("mr_err",    bus.err0, 0);
        check("mr_rdata",  bus.rdata0, 8'hC3);
        check("mr_ack1",   bus.ack1, 0);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        check("mr_idle",   bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
